cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
- Producer end of the Common Data Bus.
- Collects completed results (tag + data) from the execution units into per-unit holding FIFOs.
- Grants the bus to one unit per cycle with round-robin arbitration, and drives the registered CDB broadcast consumed by the RST, reservation stations and regfile write path.
- Returns each broadcast tag to the tag allocator so the tag can be reused.

Parameters:
- NUM_FU, 4, number of execution-unit result ports (0=int ALU, 1=mult, 2=div, 3=load/store).
- DEPTH, 2, entries per unit holding FIFO (power of two, >=2).
- TAG_W, 6, rename tag width.
- DATA_W, 32, result data width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- fu_valid  input  NUM_FU  per-unit result valid.
- fu_tag  input  NUM_FU*TAG_W  per-unit result tag; unit i occupies bits [i*TAG_W +: TAG_W].
- fu_data  input  NUM_FU*DATA_W  per-unit result data; same packing.
- fu_ready  output  NUM_FU  per-unit accept; high when that unit's FIFO has a free entry.
- cdb_valid  output  1  broadcast valid (registered).
- cdb_tag  output  TAG_W  broadcast tag (registered).
- cdb_data  output  DATA_W  broadcast data (registered).
- cdb_fu_id  output  2  unit that won the bus (registered, debug/perf).
- tag_free_valid  output  1  tag returned to allocator this cycle.
- tag_free  output  TAG_W  returned tag.

Behaviour:
- Reset: rst_n low asynchronously clears all of the following:
  - FIFO pointers and counts; fu_ready=all 1 after release.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_fu_id=0.
  - tag_free_valid=0, tag_free=0.
  - RR pointer=0.
  - Reset mid-operation discards all buffered results, with no broadcast.
- Handshake:
  - A push to FIFO i occurs on a clock edge where fu_valid[i] && fu_ready[i].
  - fu_ready[i] = (count[i] < DEPTH).
  - fu_ready[i] is a function of registered count only; it does not depend on a same-cycle pop, so there is no combinational path from the grant to ready.
- Arbitration:
  - The request vector is req[i] = count[i] != 0.
  - Round-robin: the grant goes to the first requesting unit at or after rr_ptr, wrapping modulo NUM_FU.
  - After a grant to unit g, rr_ptr <= (g+1) mod NUM_FU.
  - With no requests, rr_ptr holds.
- Broadcast:
  - On each clock edge, the grant pops the head of FIFO g.
  - The registered outputs load the popped entry: cdb_valid=1, cdb_tag, cdb_data, cdb_fu_id=g.
  - With no grant, cdb_valid<=0; cdb_tag and cdb_data hold their previous values.
- Latency:
  - A result pushed at edge N (empty FIFO, no contention) appears with cdb_valid=1 in the cycle after edge N+1.
  - Minimum is therefore 1 cycle of buffering plus 1 output register.
  - Throughput is one broadcast per cycle.
- Tag return: tag_free_valid and tag_free mirror cdb_valid and cdb_tag in the same cycle (same register stage). Tags are returned only after the broadcast.
- Simultaneous push and pop on the same FIFO: both take effect; the count is unchanged. A FIFO with count=DEPTH shows ready=0 even if it is popped that cycle.
- FIFO order is preserved within a unit. There is no ordering guarantee across units.
- Pointer wrap-around uses modulo DEPTH.
- A push while !fu_ready is ignored; the unit must hold its data.

Decomposition:
- Shared package (dispatcher_pkg):
  - TAG_W and DATA_W constants.
  - cdb_entry_t struct {tag, data}.
  - FU index enum (FU_INT, FU_MULT, FU_DIV, FU_LS).
- Sub-module cdb_fu_fifo: single-unit FIFO of cdb_entry_t with push/pop/count/ready, DEPTH parameter, asynchronous active-low reset. Instantiated NUM_FU times via generate.
- The arbiter and output register live in the top level.

Test Plan:
- Reset with rst_n=0 while unit 1 holds 2 entries, then release -> cdb_valid=0 for all following cycles, fu_ready=4'b1111, tag_free_valid=0.
- Single result, unit 0, tag=6'h05, data=32'hDEADBEEF, pushed at edge N -> cdb_valid=1, tag 05, data DEADBEEF, fu_id=0 after edge N+1; tag_free=05 in the same cycle; cdb_valid=0 after edge N+2.
- All four units push in the same cycle (tags 10,11,12,13), rr_ptr=0 -> four consecutive broadcasts in order 10,11,12,13; rr_ptr ends at 0.
- Unit 2 pushes 3 back-to-back results with DEPTH=2 and no grant possible (units 0,1 continuously backlogged) -> fu_ready[2]=0 after the 2nd push; the 3rd result is held until a slot frees; its data is broadcast exactly once and in order.
- Fairness: units 0 and 3 permanently requesting -> grants alternate 0,3,0,3; neither unit starves for more than NUM_FU-1 cycles.
- Full FIFO with a simultaneous pop and a push attempt -> the push is refused (ready=0 that cycle); the count goes DEPTH to DEPTH-1; ready=1 the next cycle.

Source files
------------

// File: rtl/dispatcher_pkg.sv
// ============================================================================
// dispatcher_pkg : shared widths, CDB entry type and execution-unit indices
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

package dispatcher_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    typedef enum logic [1:0] {
        FU_INT  = 2'd0,
        FU_MULT = 2'd1,
        FU_DIV  = 2'd2,
        FU_LS   = 2'd3
    } fu_idx_e;

endpackage

`default_nettype wire

// File: rtl/cdb_fu_fifo.sv
// ============================================================================
// cdb_fu_fifo : per-unit result holding FIFO; ready depends only on the
//               registered count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_fu_fifo
    import dispatcher_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  cdb_entry_t                   push_entry_i,
    input  logic                         pop_i,
    output cdb_entry_t                   head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         ready_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    cdb_entry_t         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               do_push;
    logic               do_pop;

    assign ready_o = (count_q < CNT_W'(DEPTH));
    assign do_push = push_i && ready_o;
    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

endmodule

`default_nettype wire

// File: rtl/cdb_broadcaster.sv
// ============================================================================
// cdb_broadcaster : per-unit result FIFOs, round-robin CDB arbiter and the
//                   registered broadcast / tag-return stage
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_broadcaster #(
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [1:0]               cdb_fu_id,
    output logic                     tag_free_valid,
    output logic [TAG_W-1:0]         tag_free
);

    import dispatcher_pkg::*;

    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    cdb_entry_t         push_entry [NUM_FU];
    cdb_entry_t         head       [NUM_FU];
    logic [CNT_W-1:0]   count      [NUM_FU];
    logic [NUM_FU-1:0]  req;
    logic [NUM_FU-1:0]  pop;
    logic               grant_valid;
    logic [RR_W-1:0]    grant_id;
    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic               cdb_valid_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [DATA_W-1:0]  cdb_data_q;
    logic [1:0]         cdb_fu_id_q;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        assign push_entry[i] = {fu_tag[i*TAG_W +: TAG_W], fu_data[i*DATA_W +: DATA_W]};
        assign req[i]        = (count[i] != '0);
        assign pop[i]        = grant_valid && (grant_id == RR_W'(i));

        cdb_fu_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst_n        (rst_n),
            .push_i       (fu_valid[i]),
            .push_entry_i (push_entry[i]),
            .pop_i        (pop[i]),
            .head_o       (head[i]),
            .count_o      (count[i]),
            .ready_o      (fu_ready[i])
        );
    end

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!grant_valid && req[(int'(rr_ptr_q) + k) % NUM_FU]) begin
                grant_valid = 1'b1;
                grant_id    = RR_W'((int'(rr_ptr_q) + k) % NUM_FU);
            end
        end
        rr_ptr_d = grant_valid ? RR_W'((int'(grant_id) + 1) % NUM_FU) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_fu_id_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= grant_valid;
            if (grant_valid) begin
                cdb_tag_q   <= head[grant_id].tag;
                cdb_data_q  <= head[grant_id].data;
                cdb_fu_id_q <= 2'(grant_id);
            end
        end
    end

    assign cdb_valid      = cdb_valid_q;
    assign cdb_tag        = cdb_tag_q;
    assign cdb_data       = cdb_data_q;
    assign cdb_fu_id      = cdb_fu_id_q;
    assign tag_free_valid = cdb_valid_q;
    assign tag_free       = cdb_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_broadcaster.sv
// ============================================================================
// tb_cdb_broadcaster : directed vector table plus hand-written multi-cycle
//                      sequences for the CDB broadcaster
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_broadcaster;

    localparam int NUM_FU = 4;
    localparam int DEPTH  = 2;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [1:0]               cdb_fu_id;
    logic                     tag_free_valid;
    logic [TAG_W-1:0]         tag_free;

    cdb_broadcaster #(
        .NUM_FU (NUM_FU),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fu_valid       (fu_valid),
        .fu_tag         (fu_tag),
        .fu_data        (fu_data),
        .fu_ready       (fu_ready),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_fu_id      (cdb_fu_id),
        .tag_free_valid (tag_free_valid),
        .tag_free       (tag_free)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   v;
        logic [23:0]  tag;
        logic [127:0] data;
        logic [3:0]   rdy;
        logic         cv;
        logic [5:0]   etag;
        logic [31:0]  edata;
        logic [1:0]   efu;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [37:0] sb [4][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
    endtask

    task automatic drive(input int u, input logic [5:0] t, input logic [31:0] d);
        fu_valid[u]               = 1'b1;
        fu_tag[u*TAG_W +: TAG_W]  = t;
        fu_data[u*DATA_W +: DATA_W] = d;
    endtask

    // Asynchronous reset mid-cycle, then idle cycles proving nothing survived.
    task automatic do_reset(input string tagname);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk({tagname, " async cdb_valid"}, 64'(cdb_valid), 64'd0);
        chk({tagname, " async tag_free_valid"}, 64'(tag_free_valid), 64'd0);
        chk({tagname, " async fu_ready"}, 64'(fu_ready), 64'hF);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("%s idle%0d cdb_valid", tagname, c), 64'(cdb_valid), 64'd0);
            chk($sformatf("%s idle%0d tag_free_valid", tagname, c), 64'(tag_free_valid), 64'd0);
            chk($sformatf("%s idle%0d fu_ready", tagname, c), 64'(fu_ready), 64'hF);
        end
        for (int u = 0; u < 4; u++) sb[u].delete();
    endtask

    function automatic logic [5:0] bp_tag(input int u, input int i);
        return 6'(32'h20 + u * 8 + i);
    endfunction

    function automatic logic [31:0] bp_data(input int u, input int i);
        return 32'hB000_0000 | 32'(u << 8) | 32'(i);
    endfunction

    task automatic check_bcast(input string tagname);
        logic [37:0] e;
        if (sb[cdb_fu_id].size() == 0) begin
            chk({tagname, " unexpected broadcast"}, 64'(cdb_tag), 64'hFFFF);
        end else begin
            e = sb[cdb_fu_id].pop_front();
            chk({tagname, " tag"}, 64'(cdb_tag), 64'(e[37:32]));
            chk({tagname, " data"}, 64'(cdb_data), 64'(e[31:0]));
            chk({tagname, " tag_free"}, 64'(tag_free), 64'(e[37:32]));
            chk({tagname, " tag_free_valid"}, 64'(tag_free_valid), 64'd1);
        end
    endtask

    vec_t tbl [9];

    initial begin
        tbl[0] = '{v:4'hF, tag:{6'h13, 6'h12, 6'h11, 6'h10},
                   data:{32'hA000_0013, 32'hA000_0012, 32'hA000_0011, 32'hA000_0010},
                   rdy:4'hF, cv:1'b0, etag:6'h00, edata:32'h0, efu:2'd0};
        tbl[1] = '{v:4'h0, tag:'0, data:'0, rdy:4'hF, cv:1'b1, etag:6'h10, edata:32'hA000_0010, efu:2'd0};
        tbl[2] = '{v:4'h0, tag:'0, data:'0, rdy:4'hF, cv:1'b1, etag:6'h11, edata:32'hA000_0011, efu:2'd1};
        tbl[3] = '{v:4'h0, tag:'0, data:'0, rdy:4'hF, cv:1'b1, etag:6'h12, edata:32'hA000_0012, efu:2'd2};
        tbl[4] = '{v:4'h0, tag:'0, data:'0, rdy:4'hF, cv:1'b1, etag:6'h13, edata:32'hA000_0013, efu:2'd3};
        tbl[5] = '{v:4'h0, tag:'0, data:'0, rdy:4'hF, cv:1'b0, etag:6'h13, edata:32'hA000_0013, efu:2'd3};
        tbl[6] = '{v:4'h1, tag:{18'h0, 6'h05}, data:{96'h0, 32'hDEAD_BEEF},
                   rdy:4'hF, cv:1'b0, etag:6'h13, edata:32'hA000_0013, efu:2'd3};
        tbl[7] = '{v:4'h0, tag:'0, data:'0, rdy:4'hF, cv:1'b1, etag:6'h05, edata:32'hDEAD_BEEF, efu:2'd0};
        tbl[8] = '{v:4'h0, tag:'0, data:'0, rdy:4'hF, cv:1'b0, etag:6'h05, edata:32'hDEAD_BEEF, efu:2'd0};

        idle_inputs();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset cdb_valid", 64'(cdb_valid), 64'd0);
        chk("reset cdb_tag", 64'(cdb_tag), 64'd0);
        chk("reset cdb_data", 64'(cdb_data), 64'd0);
        chk("reset cdb_fu_id", 64'(cdb_fu_id), 64'd0);
        chk("reset tag_free_valid", 64'(tag_free_valid), 64'd0);
        chk("reset tag_free", 64'(tag_free), 64'd0);
        chk("reset fu_ready", 64'(fu_ready), 64'hF);
        step();
        step();
        rst_n = 1'b1;

        // ---- table: four-way simultaneous push, then single-result latency ----
        for (int i = 0; i < 9; i++) begin
            fu_valid = tbl[i].v;
            fu_tag   = tbl[i].tag;
            fu_data  = tbl[i].data;
            step();
            idle_inputs();
            chk($sformatf("vec%0d fu_ready", i), 64'(fu_ready), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d cdb_valid", i), 64'(cdb_valid), 64'(tbl[i].cv));
            chk($sformatf("vec%0d cdb_tag", i), 64'(cdb_tag), 64'(tbl[i].etag));
            chk($sformatf("vec%0d cdb_data", i), 64'(cdb_data), 64'(tbl[i].edata));
            chk($sformatf("vec%0d tag_free_valid", i), 64'(tag_free_valid), 64'(tbl[i].cv));
            chk($sformatf("vec%0d tag_free", i), 64'(tag_free), 64'(tbl[i].etag));
            if (tbl[i].cv)
                chk($sformatf("vec%0d cdb_fu_id", i), 64'(cdb_fu_id), 64'(tbl[i].efu));
        end

        // ---- backpressure: unit 2 pushes 3 with units 0/1 backlogged ----
        begin
            int  sent [3];
            int  nres [3];
            logic [3:0] rdy;
            bit  done;
            sent = '{0, 0, 0};
            nres = '{6, 6, 3};
            done = 1'b0;
            for (int cyc = 0; cyc < 80 && !done; cyc++) begin
                idle_inputs();
                for (int u = 0; u < 3; u++)
                    if (sent[u] < nres[u]) drive(u, bp_tag(u, sent[u]), bp_data(u, sent[u]));
                rdy = fu_ready;
                step();
                for (int u = 0; u < 3; u++) begin
                    if (fu_valid[u] && rdy[u]) begin
                        sb[u].push_back({bp_tag(u, sent[u]), bp_data(u, sent[u])});
                        sent[u]++;
                        if (u == 2 && sent[2] == 2)
                            chk("bp fu_ready2 after 2nd push", 64'(fu_ready[2]), 64'd0);
                    end
                end
                if (cdb_valid) check_bcast("bp");
                done = (sent[0] == nres[0]) && (sent[1] == nres[1]) && (sent[2] == nres[2]) &&
                       (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0);
            end
            chk("bp all results broadcast", 64'(done), 64'd1);
            idle_inputs();
            step();
            chk("bp no extra broadcast", 64'(cdb_valid), 64'd0);
        end

        // ---- reset while units 0/1 hold entries ----
        idle_inputs();
        drive(0, 6'h3A, 32'hC000_0001);
        drive(1, 6'h3B, 32'hC000_0002);
        step();
        drive(0, 6'h3C, 32'hC000_0003);
        drive(1, 6'h3D, 32'hC000_0004);
        step();
        do_reset("midreset");

        // ---- fairness: units 0 and 3 permanently requesting ----
        begin
            int sent0, sent3, nb;
            logic [3:0] rdy;
            sent0 = 0;
            sent3 = 0;
            nb    = 0;
            for (int cyc = 0; cyc < 40 && nb < 8; cyc++) begin
                idle_inputs();
                drive(0, 6'(8 + sent0), 32'hD000_0000 | 32'(sent0));
                drive(3, 6'(24 + sent3), 32'hD300_0000 | 32'(sent3));
                rdy = fu_ready;
                step();
                if (rdy[0]) begin
                    sb[0].push_back({6'(8 + sent0), 32'hD000_0000 | 32'(sent0)});
                    sent0++;
                end
                if (rdy[3]) begin
                    sb[3].push_back({6'(24 + sent3), 32'hD300_0000 | 32'(sent3)});
                    sent3++;
                end
                if (cdb_valid) begin
                    chk($sformatf("fair grant%0d fu_id", nb), 64'(cdb_fu_id),
                        (nb % 2 == 0) ? 64'd0 : 64'd3);
                    check_bcast("fair");
                    nb++;
                end
            end
            chk("fair broadcast count", 64'(nb), 64'd8);
        end
        do_reset("postfair");

        // ---- full FIFO popped while a push is attempted ----
        drive(1, 6'h21, 32'h1111_0001);
        drive(2, 6'h22, 32'h2222_0001);
        step();
        chk("full e1 fu_ready", 64'(fu_ready), 64'hF);
        chk("full e1 cdb_valid", 64'(cdb_valid), 64'd0);
        idle_inputs();
        drive(1, 6'h23, 32'h1111_0002);
        drive(2, 6'h24, 32'h2222_0002);
        step();
        chk("full e2 cdb_tag", 64'(cdb_tag), 64'h21);
        chk("full e2 cdb_fu_id", 64'(cdb_fu_id), 64'd1);
        chk("full e2 fu_ready", 64'(fu_ready), 64'hB);
        idle_inputs();
        drive(2, 6'h3F, 32'hFFFF_FFFF);
        chk("full pre-pop fu_ready2", 64'(fu_ready[2]), 64'd0);
        step();
        idle_inputs();
        chk("full e3 cdb_valid", 64'(cdb_valid), 64'd1);
        chk("full e3 cdb_tag", 64'(cdb_tag), 64'h22);
        chk("full e3 cdb_fu_id", 64'(cdb_fu_id), 64'd2);
        chk("full e3 fu_ready", 64'(fu_ready), 64'hF);
        step();
        chk("full e4 cdb_tag", 64'(cdb_tag), 64'h23);
        chk("full e4 cdb_fu_id", 64'(cdb_fu_id), 64'd1);
        step();
        chk("full e5 cdb_tag", 64'(cdb_tag), 64'h24);
        chk("full e5 cdb_data", 64'(cdb_data), 64'h2222_0002);
        chk("full e5 cdb_fu_id", 64'(cdb_fu_id), 64'd2);
        step();
        chk("full e6 cdb_valid", 64'(cdb_valid), 64'd0);
        step();
        chk("full e7 cdb_valid", 64'(cdb_valid), 64'd0);
        chk("full e7 cdb_tag held", 64'(cdb_tag), 64'h24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
